// File: rtl/register_file_pkg.sv
// Shared CPU constants and types for the register file and its scoreboard.
package register_file_pkg;
  localparam int XLEN           = 32;
  localparam int REG_SELECT_LEN = 5;
  localparam int NUM_REGS       = 32;

  typedef logic [REG_SELECT_LEN-1:0] reg_sel_t;
endpackage

// File: rtl/register_file_scoreboard.sv
// Pending-writeback tracking: one busy bit per architectural register.
// Bits are set at issue (reserve) and cleared at writeback. Register 0 is never busy.
module regfile_scoreboard
  import register_file_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      reserve_en,
  input  logic [REG_SELECT_LEN-1:0] reserve_register,
  input  logic                      clear_en,
  input  logic [REG_SELECT_LEN-1:0] clear_register,
  output logic [NUM_REGS-1:0]       busy
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_next;

  // The reserve is applied after the clear, so a reserve and a writeback to the same register leave it busy.
  always_comb begin
    w_busy_next = r_busy;
    if (clear_en) w_busy_next[clear_register] = 1'b0;
    if (reserve_en) w_busy_next[reserve_register] = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_next;
  end

  assign busy = r_busy;

endmodule

// File: rtl/register_file.sv
// 32 x XLEN register file with registered dual read port and a pending-writeback scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read port.
module register_file
  import register_file_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      read_en,
  input  logic [REG_SELECT_LEN-1:0] register_1,
  input  logic [REG_SELECT_LEN-1:0] register_2,
  output logic [XLEN-1:0]           register_data_1,
  output logic [XLEN-1:0]           register_data_2,
  output logic                      read_valid,
  output logic                      sources_busy,
  input  logic                      write_en,
  input  logic [REG_SELECT_LEN-1:0] output_register,
  input  logic [XLEN-1:0]           output_register_data,
  input  logic                      reserve_en,
  input  logic [REG_SELECT_LEN-1:0] reserve_register
);

  logic [XLEN-1:0]     r_regs [NUM_REGS];
  logic [XLEN-1:0]     r_data_1;
  logic [XLEN-1:0]     r_data_2;
  logic                r_valid;
  logic [NUM_REGS-1:0] w_busy;
  logic                w_write;
  logic                w_src1_busy;
  logic                w_src2_busy;
  logic                w_accept;
  logic [XLEN-1:0]     w_rd_data_1;
  logic [XLEN-1:0]     w_rd_data_2;

  assign w_write = write_en && (output_register != '0);

  regfile_scoreboard u_scoreboard (
    .clk              (clk),
    .rst              (rst),
    .reserve_en       (reserve_en),
    .reserve_register (reserve_register),
    .clear_en         (write_en),
    .clear_register   (output_register),
    .busy             (w_busy)
  );

`ifdef REGFILE_BYPASS_EN
  logic w_wr_hit_1;
  logic w_wr_hit_2;

  assign w_wr_hit_1  = w_write && (output_register == register_1);
  assign w_wr_hit_2  = w_write && (output_register == register_2);
  // A register being written back this cycle is already resolved.
  assign w_src1_busy = w_busy[register_1] && !w_wr_hit_1;
  assign w_src2_busy = w_busy[register_2] && !w_wr_hit_2;
  assign w_rd_data_1 = w_wr_hit_1 ? output_register_data : r_regs[register_1];
  assign w_rd_data_2 = w_wr_hit_2 ? output_register_data : r_regs[register_2];
`else
  assign w_src1_busy = w_busy[register_1];
  assign w_src2_busy = w_busy[register_2];
  assign w_rd_data_1 = r_regs[register_1];
  assign w_rd_data_2 = r_regs[register_2];
`endif

  assign sources_busy = read_en && (w_src1_busy || w_src2_busy);
  assign w_accept     = read_en && !sources_busy;

  // Entry 0 is cleared by reset and never written, so it always reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_write) begin
      r_regs[output_register] <= output_register_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_1 <= '0;
      r_data_2 <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_data_1 <= w_rd_data_1;
        r_data_2 <= w_rd_data_2;
      end
    end
  end

  assign register_data_1 = r_data_1;
  assign register_data_2 = r_data_2;
  assign read_valid      = r_valid;

endmodule
